// File: rtl/bcd_digit_extractor.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_extractor
// Description : Sequential binary-to-BCD converter, one divide-by-10 per cycle,
//               units digit first; result latched with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_extractor #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    work;
    logic [WIDTH-1:0]    quot;
    logic [3:0]          rem;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] scratch_next;
    logic                accept;
    logic                last_digit;

    assign quot       = work / WIDTH'(10);
    assign rem        = 4'(work - quot * WIDTH'(10));
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_digit = (state == CONV) && (idx == LAST_IDX);

    // The final bcd must include the digit produced on the exit edge.
    always_comb begin
        scratch_next               = scratch;
        scratch_next[idx*4 +: 4]   = rem;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = start ? CONV : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= '0;
            idx      <= '0;
            scratch  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                work    <= bin;
                idx     <= '0;
                scratch <= '0;
                busy    <= 1'b1;
            end else if (state == CONV) begin
                work    <= quot;
                scratch <= scratch_next;
                idx     <= idx + 1'b1;
                if (last_digit) begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    bcd      <= scratch_next;
                    overflow <= (quot != '0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_extractor.sv
`default_nettype none
// Testbench for bcd_digit_extractor: behavioural timeline model plus literal checks.
module tb_bcd_digit_extractor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0;
    logic [15:0] bin_a = '0;
    logic        busy_a, done_a, ovf_a;
    logic [19:0] bcd_a;
    logic        start_b = 1'b0;
    logic [9:0]  bin_b = '0;
    logic        busy_b, done_b, ovf_b;
    logic [11:0] bcd_b;

    int checks = 0;
    int passes = 0;

    bcd_digit_extractor #(.WIDTH(16), .DIGITS(5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
    );

    bcd_digit_extractor #(.WIDTH(10), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int unsigned v, input int nd);
        logic [19:0] r;
        r = '0;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic exceeds(input int unsigned v, input int nd);
        int unsigned lim;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model for instance A: a conversion occupies 5 edges after acceptance.
    int          cnt = 0;
    int unsigned pend = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    logic [19:0] m_bcd = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_bcd = '0; m_ovf = 1'b0;
        end else begin
            m_done = 1'b0;
            if (cnt == 1) begin
                cnt    = 0;
                m_busy = 1'b0;
                m_done = 1'b1;
                m_bcd  = to_bcd(pend, 5);
                m_ovf  = exceeds(pend, 5);
            end else if (cnt > 1) begin
                cnt--;
            end else if (start_a) begin
                pend   = 32'(bin_a);
                cnt    = 5;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({busy_a, done_a, bcd_a, ovf_a} === {m_busy, m_done, m_bcd, m_ovf}) passes++;
        else $display("FAIL cycle_a: got busy=%b done=%b bcd=%h ovf=%b expected busy=%b done=%b bcd=%h ovf=%b",
                      busy_a, done_a, bcd_a, ovf_a, m_busy, m_done, m_bcd, m_ovf);
    end

    task automatic wait_done_a(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (done_a) ok = 1'b1;
        end
        checks++;
        if (ok) passes++;
        else $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    endtask

    task automatic wait_done_b(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (done_b) ok = 1'b1;
        end
        checks++;
        if (ok) passes++;
        else $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    endtask

    task automatic run_a(input logic [15:0] v, input logic [19:0] exp_bcd, input string name);
        start_a = 1'b1;
        bin_a   = v;
        @(posedge clk);
        #1 start_a = 1'b0;
        bin_a = 16'($urandom);
        wait_done_a(name);
        chk(name, 32'(bcd_a), 32'(exp_bcd));
        chk({name, "_ovf"}, 32'(ovf_a), 32'(0));
    endtask

    task automatic run_b(input logic [9:0] v, input logic [11:0] exp_bcd, input logic exp_ovf,
                         input string name);
        start_b = 1'b1;
        bin_b   = v;
        @(posedge clk);
        #1 start_b = 1'b0;
        bin_b = 10'($urandom);
        wait_done_b(name);
        chk(name, 32'(bcd_b), 32'(exp_bcd));
        chk({name, "_ovf"}, 32'(ovf_b), 32'(exp_ovf));
    endtask

    initial begin
        int seen;
        logic [9:0] v;
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        chk("reset_a", {busy_a, done_a, ovf_a, 29'(bcd_a)}, 32'(0));
        chk("reset_b", {busy_b, done_b, ovf_b, 29'(bcd_b)}, 32'(0));
        @(posedge clk);
        #1;
        run_a(16'd12345, 20'h12345, "bin_12345");
        run_a(16'd0,     20'h00000, "bin_0");
        run_a(16'd65535, 20'h65535, "bin_65535");

        // start during CONV is ignored; start held through DONE chains directly.
        start_a = 1'b1; bin_a = 16'd4321;
        @(posedge clk);
        #1 start_a = 1'b0;
        @(posedge clk);
        #1 start_a = 1'b1; bin_a = 16'd7;
        wait_done_a("ignored_start");
        chk("ignored_start", 32'(bcd_a), 32'h04321);
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        chk("no_idle_gap", 32'(busy_a), 32'(1));
        wait_done_a("back_to_back");
        chk("back_to_back", 32'(bcd_a), 32'h00007);

        // Reset mid-conversion.
        run_a(16'd12345, 20'h12345, "pre_reset");
        start_a = 1'b1; bin_a = 16'd4321;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", {busy_a, done_a, ovf_a, 29'(bcd_a)}, 32'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (8) @(negedge clk) if (done_a) seen++;
        chk("no_done_after_reset", 32'(seen), 32'(0));
        run_a(16'd500, 20'h00500, "bin_500");

        // Narrow instance: overflow and boundary values.
        run_b(10'd1023, 12'h023, 1'b1, "b_1023");
        run_b(10'd999,  12'h999, 1'b0, "b_999");
        run_b(10'd1000, 12'h000, 1'b1, "b_1000");
        for (int i = 0; i < 15; i++) begin
            v = 10'($urandom_range(0, 1023));
            run_b(v, 12'(to_bcd(32'(v), 3)), exceeds(32'(v), 3), "b_random");
        end

        // Random start/bin traffic on instance A, checked every cycle by the model.
        repeat (400) begin
            @(posedge clk);
            #1 start_a = ($urandom_range(0, 2) == 0);
            bin_a = 16'($urandom);
        end
        start_a = 1'b0;
        repeat (10) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
